// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU operation codes, result selects and the decoded control bundle for the RV32I decode stage.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // M codes sit at 1_0xxx so the low bits are the instruction's funct3
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       is_jalr;
        logic       alu_src;
        logic       src_a_sel;
        logic [1:0] result_src;
        alu_t       alu_ctrl;
        logic [2:0] branch_type;
        logic [2:0] load_type;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
    } ctrl_t;

    function automatic alu_t base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I instruction decoder with immediate generation and source-use flags; RV_M_EXT_EN adds the M extension.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output ctrl_t           o_ctrl,
    output logic [XLEN-1:0] o_imm,
    output logic            o_use_rs1,
    output logic            o_use_rs2
);

`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    alu_t            w_r_alu, w_i_alu;
    logic            w_r_ok, w_i_ok, w_ok;

    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    assign w_imm_i = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

    assign w_r_ok  = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) || (M_EN && w_f7 == 7'b0000001);
    assign w_r_alu = (w_f7 == 7'b0000001) ? alu_t'({2'b10, w_f3}) : w_f7[5] ? (w_f3 == 3'b000 ? ALU_SUB : ALU_SRA) : base_alu(w_f3);
    assign w_i_ok  = (w_f3 == 3'b001) ? (w_f7 == 7'b0000000) : (w_f3 == 3'b101) ? (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) : 1'b1;
    assign w_i_alu = (w_f3 == 3'b101 && w_f7[5]) ? ALU_SRA : base_alu(w_f3);

    always_comb begin
        o_ctrl     = '0;
        o_ctrl.rd  = i_instr[11:7];
        o_ctrl.rs1 = i_instr[19:15];
        o_ctrl.rs2 = i_instr[24:20];
        o_imm      = '0;
        o_use_rs1  = 1'b0;
        o_use_rs2  = 1'b0;
        w_ok       = 1'b1;
        case (w_op)
            OP_R: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_ctrl  = w_r_alu;
                o_use_rs1        = 1'b1;
                o_use_rs2        = 1'b1;
                w_ok             = w_r_ok;
            end
            OP_I: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_ctrl  = w_i_alu;
                o_imm            = w_imm_i;
                o_use_rs1        = 1'b1;
                w_ok             = w_i_ok;
            end
            OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_MEM;
                o_ctrl.load_type  = w_f3;
                o_imm             = w_imm_i;
                o_use_rs1         = 1'b1;
                w_ok              = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
            end
            OP_STORE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_imm            = w_imm_s;
                o_use_rs1        = 1'b1;
                o_use_rs2        = 1'b1;
                w_ok             = (w_f3 < 3'b011);
            end
            OP_BRANCH: begin
                o_ctrl.branch      = 1'b1;
                o_ctrl.alu_ctrl    = ALU_SUB;
                o_ctrl.branch_type = w_f3;
                o_imm              = w_imm_b;
                o_use_rs1          = 1'b1;
                o_use_rs2          = 1'b1;
                w_ok               = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            OP_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jump       = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.src_a_sel  = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_imm             = w_imm_j;
            end
            OP_JALR: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.jump       = 1'b1;
                o_ctrl.is_jalr    = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.result_src = RES_PC4;
                o_imm             = w_imm_i;
                o_use_rs1         = 1'b1;
                w_ok              = (w_f3 == 3'b000);
            end
            OP_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_ctrl  = ALU_PASSB;
                o_imm            = w_imm_u;
            end
            OP_AUIPC: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.src_a_sel = 1'b1;
                o_imm            = w_imm_u;
            end
            default: w_ok = 1'b0;
        endcase
        if (!w_ok) begin
            o_ctrl         = '0;
            o_ctrl.illegal = 1'b1;
            o_imm          = '0;
            o_use_rs1      = 1'b0;
            o_use_rs2      = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered valid/ready decode stage with flush and one-bubble load-use stall; RV_M_EXT_EN (in decode_comb) enables the M extension.
module decode_stage
    import decode_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            reg_write,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            is_jalr,
    output logic            alu_src,
    output logic            src_a_sel,
    output logic [1:0]      result_src,
    output logic [4:0]      alu_ctrl,
    output logic [2:0]      branch_type,
    output logic [2:0]      load_type,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    ctrl_t           w_ctrl, r_ctrl;
    logic [XLEN-1:0] w_imm, r_imm, r_pc;
    logic            w_use_rs1, w_use_rs2, w_hz, w_acc, r_valid;

    decode_comb #(.XLEN(XLEN)) u_dec (
        .i_instr   (instr),
        .o_ctrl    (w_ctrl),
        .o_imm     (w_imm),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2)
    );

    assign w_hz = in_valid && r_valid && (r_ctrl.result_src == RES_MEM) && (r_ctrl.rd != 5'd0) &&
                  ((w_use_rs1 && w_ctrl.rs1 == r_ctrl.rd) || (w_use_rs2 && w_ctrl.rs2 == r_ctrl.rd));
    assign in_ready = !rst && !flush && !w_hz && (!r_valid || out_ready);
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_imm   <= '0;
            r_pc    <= RESET_PC;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_imm   <= w_imm;
            r_pc    <= pc;
        end else if (flush || out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign reg_write   = r_ctrl.reg_write;
    assign mem_write   = r_ctrl.mem_write;
    assign branch      = r_ctrl.branch;
    assign jump        = r_ctrl.jump;
    assign is_jalr     = r_ctrl.is_jalr;
    assign alu_src     = r_ctrl.alu_src;
    assign src_a_sel   = r_ctrl.src_a_sel;
    assign result_src  = r_ctrl.result_src;
    assign alu_ctrl    = r_ctrl.alu_ctrl;
    assign branch_type = r_ctrl.branch_type;
    assign load_type   = r_ctrl.load_type;
    assign rd          = r_ctrl.rd;
    assign rs1         = r_ctrl.rs1;
    assign rs2         = r_ctrl.rs2;
    assign imm         = r_imm;
    assign pc_out      = r_pc;
    assign illegal     = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (expectations follow RV_M_EXT_EN when defined).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, imm, pc_out;
    logic        reg_write, mem_write, branch, jump, is_jalr, alu_src, src_a_sel, illegal;
    logic [1:0]  result_src;
    logic [4:0]  alu_ctrl, rd, rs1, rs2;
    logic [2:0]  branch_type, load_type;
    int          n_chk = 0;
    int          n_pass = 0;

`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic        rw;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [1:0]  bj;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(32'h40)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
        .is_jalr     (is_jalr),
        .alu_src     (alu_src),
        .src_a_sel   (src_a_sel),
        .result_src  (result_src),
        .alu_ctrl    (alu_ctrl),
        .branch_type (branch_type),
        .load_type   (load_type),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .pc_out      (pc_out),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] ins, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
    endtask

    initial begin
        vecs[0] = '{32'h02208033, !M_EN, M_EN, M_EN ? 5'd16 : 5'd0, 32'h0, 2'b00};
        vecs[1] = '{32'h0000007F, 1'b1, 1'b0, 5'd0, 32'h0, 2'b00};
        vecs[2] = '{32'h40208033, 1'b0, 1'b1, 5'd1, 32'h0, 2'b00};
        vecs[3] = '{32'h40109093, 1'b1, 1'b0, 5'd0, 32'h0, 2'b00};
        vecs[4] = '{32'h4010D093, 1'b0, 1'b1, 5'd7, 32'h401, 2'b00};
        vecs[5] = '{32'h008000EF, 1'b0, 1'b1, 5'd0, 32'h8, 2'b01};
        vecs[6] = '{32'hFE208EE3, 1'b0, 1'b0, 5'd1, 32'hFFFFFFFC, 2'b10};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pc_out", pc_out, 32'h40);
        check("rst_reg_write", reg_write, 0);
        check("rst_imm", imm, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        feed(32'h00500093, 32'h100);
        tick();
        check("addi_valid", out_valid, 1);
        check("addi_rw", reg_write, 1);
        check("addi_alu_src", alu_src, 1);
        check("addi_rd", rd, 1);
        check("addi_imm", imm, 5);
        check("addi_pc", pc_out, 32'h100);
        check("addi_illegal", illegal, 0);

        feed(32'h00012283, 32'h104);
        tick();
        check("lw_result_src", result_src, 2'b01);
        check("lw_load_type", load_type, 3'b010);
        check("lw_rd", rd, 5);
        feed(32'h00128333, 32'h108);
        #1;
        check("hz_rs1_in_ready", in_ready, 0);
        tick();
        check("hz_bubble", out_valid, 0);
        check("hz_clear_in_ready", in_ready, 1);
        tick();
        check("add_valid", out_valid, 1);
        check("add_rd_rs", {rd, rs1, rs2}, {5'd6, 5'd5, 5'd1});
        check("add_pc", pc_out, 32'h108);

        feed(32'h00012003, 32'h10C);
        tick();
        feed(32'h00100333, 32'h110);
        #1;
        check("hz_x0_in_ready", in_ready, 1);
        tick();
        check("hz_x0_pc", pc_out, 32'h110);

        feed(32'h00012283, 32'h114);
        tick();
        feed(32'h0051A223, 32'h118);
        #1;
        check("hz_rs2_in_ready", in_ready, 0);
        tick();
        check("hz_rs2_bubble", out_valid, 0);
        tick();
        check("sw_ctrl", {mem_write, reg_write, out_valid}, 3'b101);
        check("sw_imm", imm, 4);

        out_ready = 1'b0;
        feed(32'hFFF00113, 32'h200);
        #1;
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {out_valid, pc_out, imm}, {1'b1, 32'h118, 32'h4});
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        tick();
        check("bp_next_pc", pc_out, 32'h200);
        check("addi_neg_imm", imm, 32'hFFFFFFFF);

        feed(32'h123451B7, 32'h300);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_not_consumed", pc_out, 32'h200);
        flush = 1'b0;
        tick();
        check("lui_pc", pc_out, 32'h300);
        check("lui_imm", imm, 32'h12345000);
        check("lui_alu", alu_ctrl, 5'd10);

        for (int i = 0; i < 7; i++) begin
            feed(vecs[i].ins, 32'h400 + 32'(4 * i));
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
            check($sformatf("vec%0d_rw", i), reg_write, vecs[i].rw);
            check($sformatf("vec%0d_alu", i), alu_ctrl, vecs[i].alu);
            check($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
            check($sformatf("vec%0d_bj", i), {branch, jump}, vecs[i].bj);
        end

        feed(32'h00500093, 32'h500);
        rst = 1'b1;
        tick();
        check("rst_wins_valid", out_valid, 0);
        check("rst_wins_pc", pc_out, 32'h40);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
